// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 MAR/MDR bus.
// A request is accepted in IDLE, waits WAIT_CYCLES, then performs one access on an
// internal word RAM or on the memory-mapped switch/hex I/O register. Completion is
// signalled by a one-cycle R pulse.
//
// Ports:
//   Clk       rising-edge clock
//   Reset     asynchronous reset, active-low
//   MAR       request address (sampled in IDLE only)
//   MDR       write data (sampled in IDLE only)
//   MEM_EN    level request strobe, held by the initiator until R is seen
//   WE        1 = write, 0 = read (sampled with MEM_EN)
//   SW        switch inputs, returned on reads of IO_ADDR
//   MEM_DATA  registered read data, holds until the next read completes
//   R         one-cycle ready pulse per completed access
//   HEX_OUT   I/O register written by stores to IO_ADDR
//   BUSY      high in every state except IDLE
module lc3_mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        MEM_EN,
    input  logic        WE,
    input  logic [15:0] SW,
    output logic [15:0] MEM_DATA,
    output logic        R,
    output logic [15:0] HEX_OUT,
    output logic        BUSY
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP,
        S_HOLD
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [DATA_W-1:0]   addr_q, wdata_q;
    logic                we_q;
    logic                latch_en;
    logic                ram_we;
    logic                r_d, busy_d;
    logic [DATA_W-1:0]   mem_data_d, hex_d;
    logic [DATA_W-1:0]   rd_word;
    logic                is_io;

    logic [DATA_W-1:0]   ram [DEPTH];

    // Upper address bits are dropped for RAM indexing, so addresses alias.
    assign rd_word = ram[addr_q[ADDR_W-1:0]];
    assign is_io   = (addr_q == IO_ADDR);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        latch_en   = 1'b0;
        ram_we     = 1'b0;
        r_d        = 1'b0;
        mem_data_d = MEM_DATA;
        hex_d      = HEX_OUT;

        case (state)
            S_IDLE: begin
                if (MEM_EN) begin
                    latch_en = 1'b1;
                    cnt_d    = CNT_W'(WAIT_CYCLES);
                    state_d  = (WAIT_CYCLES != 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                // Dropping the strobe during the wait abandons the request.
                if (!MEM_EN) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_ACCESS: begin
                if (is_io) begin
                    if (we_q) hex_d = wdata_q;
                    else      mem_data_d = SW;
                end else begin
                    if (we_q) ram_we = 1'b1;
                    else      mem_data_d = rd_word;
                end
                r_d     = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = MEM_EN ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                // A held strobe must be released before a new request is taken.
                if (!MEM_EN) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, request latch and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            MEM_DATA <= '0;
            HEX_OUT  <= '0;
            R        <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            MEM_DATA <= mem_data_d;
            HEX_OUT  <= hex_d;
            R        <= r_d;
            BUSY     <= busy_d;
            if (latch_en) begin
                addr_q  <= MAR;
                wdata_q <= MDR;
                we_q    <= WE;
            end
        end
    end

    // Word RAM; contents are deliberately not reset.
    always_ff @(posedge Clk) begin
        if (ram_we) ram[addr_q[ADDR_W-1:0]] <= wdata_q;
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: two instances (2 wait states and 0 wait states)
// driven by directed scenarios followed by randomized traffic, checked against a
// word-level memory model.
module tb_lc3_mem_responder;

    logic        Clk;
    logic        Reset;
    logic [15:0] mar    [2];
    logic [15:0] mdr    [2];
    logic        mem_en [2];
    logic        we     [2];
    logic [15:0] sw     [2];
    logic [15:0] mem_data [2];
    logic        r      [2];
    logic [15:0] hex_out [2];
    logic        busy   [2];

    int checks = 0;
    int errors = 0;

    // Reference model: word memory indexed by the low 10 address bits.
    bit   [15:0] mref [2][1024];
    bit          mval [2][1024];
    logic [15:0] exp_md  [2];
    logic [15:0] exp_hex [2];

    lc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2), .IO_ADDR(16'hFFFF)) u_w2 (
        .Clk(Clk), .Reset(Reset), .MAR(mar[0]), .MDR(mdr[0]), .MEM_EN(mem_en[0]),
        .WE(we[0]), .SW(sw[0]), .MEM_DATA(mem_data[0]), .R(r[0]),
        .HEX_OUT(hex_out[0]), .BUSY(busy[0])
    );

    lc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .IO_ADDR(16'hFFFF)) u_w0 (
        .Clk(Clk), .Reset(Reset), .MAR(mar[1]), .MDR(mdr[1]), .MEM_EN(mem_en[1]),
        .WE(we[1]), .SW(sw[1]), .MEM_DATA(mem_data[1]), .R(r[1]),
        .HEX_OUT(hex_out[1]), .BUSY(busy[1])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // One complete request; MAR/MDR/WE are scrambled while busy to prove they are ignored.
    task automatic do_access(input int d, input bit w, input logic [15:0] a,
                             input logic [15:0] dat, input bit hold, input string tag);
        int r_at   = 0;
        int pulses = 0;
        int idx    = int'(a[9:0]);
        @(negedge Clk);
        mar[d] = a; mdr[d] = dat; we[d] = w; mem_en[d] = 1'b1;
        for (int n = 1; n <= 20 && r_at == 0; n++) begin
            @(posedge Clk); #1;
            mar[d] = 16'($urandom); mdr[d] = 16'($urandom); we[d] = 1'($urandom);
            if (r[d]) begin r_at = n; pulses++; end
        end
        if (hold) begin
            repeat (3) begin
                @(posedge Clk); #1;
                if (r[d]) pulses++;
            end
            check({tag, "_hold_busy"}, 32'(busy[d]), 32'd1);
        end
        @(negedge Clk);
        mem_en[d] = 1'b0;
        @(posedge Clk); #1;
        if (r[d]) pulses++;

        if (a == 16'hFFFF) begin
            if (w) exp_hex[d] = dat;
            else   exp_md[d]  = sw[d];
        end else if (w) begin
            mref[d][idx] = dat;
            mval[d][idx] = 1'b1;
        end else if (mval[d][idx]) begin
            exp_md[d] = mref[d][idx];
        end

        check({tag, "_r_edge"}, 32'(r_at), 32'(wait_of(d) + 2));
        check({tag, "_r_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_idle"}, 32'(busy[d]), 32'd0);
        if (a == 16'hFFFF || w || mval[d][idx])
            check({tag, "_mem_data"}, 32'(mem_data[d]), 32'(exp_md[d]));
        check({tag, "_hex"}, 32'(hex_out[d]), 32'(exp_hex[d]));
    endtask

    // Write request abandoned by dropping MEM_EN during the wait states (instance 0).
    task automatic do_abort(input logic [15:0] a, input logic [15:0] dat);
        int pulses = 0;
        @(negedge Clk);
        mar[0] = a; mdr[0] = dat; we[0] = 1'b1; mem_en[0] = 1'b1;
        @(posedge Clk); #1;
        if (r[0]) pulses++;
        check("abort_busy_in_wait", 32'(busy[0]), 32'd1);
        @(negedge Clk);
        mem_en[0] = 1'b0;
        repeat (4) begin
            @(posedge Clk); #1;
            if (r[0]) pulses++;
        end
        check("abort_no_r", 32'(pulses), 32'd0);
        check("abort_idle", 32'(busy[0]), 32'd0);
    endtask

    logic [9:0] pool [8];

    initial begin
        for (int d = 0; d < 2; d++) begin
            mar[d] = '0; mdr[d] = '0; mem_en[d] = 1'b0; we[d] = 1'b0; sw[d] = '0;
            exp_md[d] = '0; exp_hex[d] = '0;
        end
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_r", 32'(r[d]), 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_mem_data", 32'(mem_data[d]), 32'd0);
            check("rst_hex", 32'(hex_out[d]), 32'd0);
        end
        @(negedge Clk);
        Reset = 1'b1;

        // Two wait states: write with held strobe, then read back.
        do_access(0, 1'b1, 16'h0010, 16'h1234, 1'b1, "w2_write");
        do_access(0, 1'b0, 16'h0010, 16'h0000, 1'b0, "w2_read");
        check("w2_read_value", 32'(mem_data[0]), 32'h1234);

        // Zero wait states: read with held strobe sits in HOLD without a second R.
        do_access(1, 1'b1, 16'h0010, 16'hCAFE, 1'b0, "w0_write");
        do_access(1, 1'b0, 16'h0010, 16'h0000, 1'b1, "w0_read_hold");
        check("w0_read_value", 32'(mem_data[1]), 32'hCAFE);

        // I/O register: switch read, hex write, RAM at the aliased index untouched.
        sw[0] = 16'h00A5;
        do_access(0, 1'b1, 16'h03FF, 16'h7A7A, 1'b0, "io_pre");
        do_access(0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, "io_read");
        check("io_read_value", 32'(mem_data[0]), 32'h00A5);
        do_access(0, 1'b1, 16'hFFFF, 16'hBEEF, 1'b0, "io_write");
        check("io_hex_value", 32'(hex_out[0]), 32'hBEEF);
        check("io_write_keeps_md", 32'(mem_data[0]), 32'h00A5);
        do_access(0, 1'b0, 16'h03FF, 16'h0000, 1'b0, "io_ram_intact");
        check("io_ram_value", 32'(mem_data[0]), 32'h7A7A);

        // Alias and abort.
        do_access(0, 1'b1, 16'h0403, 16'h5555, 1'b0, "alias_write");
        do_access(0, 1'b0, 16'h0003, 16'h0000, 1'b0, "alias_read");
        check("alias_value", 32'(mem_data[0]), 32'h5555);
        do_access(0, 1'b1, 16'h0030, 16'h1111, 1'b0, "abort_pre");
        do_abort(16'h0030, 16'h2222);
        do_access(0, 1'b0, 16'h0030, 16'h0000, 1'b0, "abort_read");
        check("abort_value", 32'(mem_data[0]), 32'h1111);

        // Back-to-back read, write, read with one-edge gaps.
        do_access(0, 1'b1, 16'h0020, 16'h0F0F, 1'b0, "b2b_pre");
        do_access(0, 1'b0, 16'h0020, 16'h0000, 1'b0, "b2b_rd1");
        do_access(0, 1'b1, 16'h0020, 16'hA5C3, 1'b0, "b2b_wr");
        do_access(0, 1'b0, 16'h0020, 16'h0000, 1'b0, "b2b_rd2");
        check("b2b_value", 32'(mem_data[0]), 32'hA5C3);

        // Reset in the middle of a write's wait states.
        do_access(0, 1'b1, 16'h0005, 16'h0BAD, 1'b0, "rst_pre");
        @(negedge Clk);
        mar[0] = 16'h0005; mdr[0] = 16'h7777; we[0] = 1'b1; mem_en[0] = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_md[d] = '0; exp_hex[d] = '0;
        end
        check("midrst_r", 32'(r[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_hex", 32'(hex_out[0]), 32'd0);
        check("midrst_mem_data", 32'(mem_data[0]), 32'd0);
        mem_en[0] = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        do_access(0, 1'b0, 16'h0005, 16'h0000, 1'b0, "midrst_read");
        check("midrst_value", 32'(mem_data[0]), 32'h0BAD);

        // Randomized traffic over a small index pool with random upper bits.
        pool = '{10'h000, 10'h003, 10'h010, 10'h020, 10'h155, 10'h2AA, 10'h3FE, 10'h3FF};
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++)
                do_access(d, 1'b1, {6'd0, pool[i]}, 16'($urandom), 1'b0, "rnd_fill");
        for (int t = 0; t < 60; t++) begin
            int         d   = int'($urandom_range(0, 1));
            logic [9:0] idx = pool[$urandom_range(0, 7)];
            logic [15:0] a  = {6'($urandom), idx};
            if ($urandom_range(0, 5) == 0) a = 16'hFFFF;
            sw[d] = 16'($urandom);
            do_access(d, 1'($urandom), a, 16'($urandom), 1'($urandom), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
